// File: rtl/modulo_down_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_down_counter_pkg
//  Description : Shared types and helpers for the modulo-K down counter.
//                - FSM state encoding.
//                - Wide compare and clamp helpers, sized so that K = 2**W
//                  still fits.
//  Revision    : 1.0 - initial release
// ============================================================================
package modulo_down_counter_pkg;

    // Helper arithmetic width: one bit wider than the largest supported
    // count width (64). Callers zero-extend into this width and cast the
    // result back down.
    localparam int CALC_W = 65;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        EXPIRED = 1'b1
    } state_t;

    // Unsigned a >= b at CALC_W bits, so that the modulus itself is never truncated.
    function automatic logic ge_wide(input logic [CALC_W-1:0] a,
                                     input logic [CALC_W-1:0] b);
        return (a >= b);
    endfunction

    // min(val, k-1). The caller guarantees k >= 1.
    function automatic logic [CALC_W-1:0] clamp_val(input logic [CALC_W-1:0] val,
                                                    input logic [CALC_W-1:0] k);
        return ge_wide(val, k) ? (k - CALC_W'(1)) : val;
    endfunction

endpackage : modulo_down_counter_pkg
`default_nettype wire

// File: rtl/modulo_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_down_counter
//  Description : Loadable modulo-K down counter.
//                - Counts K-1 .. 0, then either reloads K-1 (auto-reload) or
//                  parks at 0 in EXPIRED (one-shot).
//                - Registered one-cycle borrow pulse at terminal count.
//                - Registered one-cycle load_err pulse when a load is clamped.
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_down_counter
    import modulo_down_counter_pkg::*;
#(
    parameter longint unsigned K = 16,
    parameter int              W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         one_shot,
    output logic [W-1:0] count,
    output logic         borrow,
    output logic         done,
    output logic         zero,
    output logic         load_err
);

    // Terminal reload value. K-1 fits in W bits even when K = 2**W.
    localparam logic [W-1:0] C_KMAX = W'(K - 64'd1);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         r_borrow;
    logic         w_borrow_next;
    logic         r_load_err;
    logic         w_load_err_next;
    logic         w_load_over;
    logic         w_count_zero;

    // The load range check runs one bit wider than the count, so K = 2**W is handled.
    assign w_load_over  = ge_wide(CALC_W'(load_val), CALC_W'(K));
    assign w_count_zero = (r_count == '0);

    // Next-state logic. Priority is load, then enabled RUN, then hold.
    // Borrow and load_err default low, so each pulse lasts a single cycle.
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_borrow_next   = 1'b0;
        w_load_err_next = 1'b0;

        if (load) begin
            w_count_next    = W'(clamp_val(CALC_W'(load_val), CALC_W'(K)));
            w_state_next    = RUN;
            w_load_err_next = w_load_over;
        end else if ((r_state == RUN) && en) begin
            if (w_count_zero) begin
                // Terminal count. one_shot as sampled on this edge picks wrap or expire.
                w_borrow_next = 1'b1;
                if (one_shot) begin
                    w_state_next = EXPIRED;
                end else begin
                    w_count_next = C_KMAX;
                end
            end else begin
                w_count_next = r_count - W'(1);
            end
        end
    end

    // State, count and pulse registers. Reset is asynchronous and returns the counter to a full RUN period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_count    <= C_KMAX;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_borrow   <= w_borrow_next;
            r_load_err <= w_load_err_next;
        end
    end

    assign count    = r_count;
    assign borrow   = r_borrow;
    assign load_err = r_load_err;
    assign done     = (r_state == EXPIRED);
    assign zero     = w_count_zero;

endmodule : modulo_down_counter
`default_nettype wire
